// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Writeback-slot scoreboard for a pipelined MIPS core with a single register
// file write port and execution units of latency 1..MAX_LAT. Slot k holds the
// register write that lands k cycles from now. Every cycle the slots shift
// toward slot 0, and an accepted issue of latency L is placed in slot L-1.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset, clears every slot
//   issue_valid  decode holds a valid instruction
//   issue_wr     instruction writes a register
//   issue_rd     destination register
//   issue_lat    issue-to-writeback latency (0 -> 1, >MAX_LAT -> MAX_LAT)
//   src1_en/src1, src2_en/src2  source operands
//   flush        decode instruction is squashed this cycle
//   stall        hold fetch/decode (RAW | structural | WAW), combinational
//   fwd1, fwd2   take the operand from the writeback bus
//   wb_valid     a tracked write lands this cycle (slot 0)
//   wb_rd        register being written, 0 when wb_valid is low
//   pending_cnt  number of valid slots
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int MAX_LAT    = 8,
    parameter int CNT_W      = $clog2(MAX_LAT + 1),
    parameter int WB_BYPASS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic                  issue_wr,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [CNT_W-1:0]      issue_lat,
    input  logic                  src1_en,
    input  logic                  src2_en,
    input  logic [REG_ADDR_W-1:0] src1,
    input  logic [REG_ADDR_W-1:0] src2,
    input  logic                  flush,
    output logic                  stall,
    output logic                  fwd1,
    output logic                  fwd2,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [CNT_W-1:0]      pending_cnt
);

    localparam logic [REG_ADDR_W-1:0] ZERO_REG  = {REG_ADDR_W{1'b0}};
    localparam logic                  BYPASS_EN = (WB_BYPASS != 0) ? 1'b1 : 1'b0;
    // With bypass, a match in slot 0 forwards; otherwise it stalls like any other.
    localparam logic [MAX_LAT-1:0]    RAW_MASK  = (WB_BYPASS != 0) ?
                                                  {{(MAX_LAT-1){1'b1}}, 1'b0} :
                                                  {MAX_LAT{1'b1}};

    // Clamp the requested latency into 1..MAX_LAT.
    function automatic logic [CNT_W-1:0] clamp_lat(input logic [CNT_W-1:0] lat);
        logic [CNT_W-1:0] res;
        if (lat == {CNT_W{1'b0}}) begin
            res = CNT_W'(1);
        end else if (lat > CNT_W'(MAX_LAT)) begin
            res = CNT_W'(MAX_LAT);
        end else begin
            res = lat;
        end
        return res;
    endfunction

    // Number of set bits in the slot valid vector.
    function automatic logic [CNT_W-1:0] popcount(input logic [MAX_LAT-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = {CNT_W{1'b0}};
        for (int i = 0; i < MAX_LAT; i++) begin
            cnt = cnt + CNT_W'(v[i]);
        end
        return cnt;
    endfunction

    logic [MAX_LAT-1:0]    slot_valid_r;
    logic [REG_ADDR_W-1:0] slot_rd_r [MAX_LAT];
    logic [CNT_W-1:0]      pending_r;

    logic [MAX_LAT-1:0]    nxt_valid_s;
    logic [REG_ADDR_W-1:0] nxt_rd_s [MAX_LAT];
    logic [MAX_LAT-1:0]    load_s;

    logic [CNT_W-1:0]      eff_lat_s;
    logic [MAX_LAT-1:0]    hit1_s;
    logic [MAX_LAT-1:0]    hit2_s;
    logic [MAX_LAT-1:0]    hitd_s;
    logic                  raw1_s;
    logic                  raw2_s;
    logic                  struct_s;
    logic                  waw_s;
    logic                  stall_s;
    logic                  fwd1_s;
    logic                  fwd2_s;
    logic                  accept_s;

    // Effective latency of the instruction in decode.
    always_comb begin
        eff_lat_s = clamp_lat(issue_lat);
    end

    // Per-slot register matches for both sources and the destination.
    always_comb begin
        hit1_s = {MAX_LAT{1'b0}};
        hit2_s = {MAX_LAT{1'b0}};
        hitd_s = {MAX_LAT{1'b0}};
        for (int k = 0; k < MAX_LAT; k++) begin
            hit1_s[k] = slot_valid_r[k] && (src1 != ZERO_REG) && (slot_rd_r[k] == src1);
            hit2_s[k] = slot_valid_r[k] && (src2 != ZERO_REG) && (slot_rd_r[k] == src2);
            hitd_s[k] = slot_valid_r[k] && (slot_rd_r[k] == issue_rd);
        end
    end

    // Hazard classification, stall and forwarding selects.
    always_comb begin
        struct_s = 1'b0;
        waw_s    = 1'b0;
        // Slot L is about to shift into slot L-1, which the new write needs.
        for (int k = 1; k < MAX_LAT; k++) begin
            struct_s = struct_s | ((eff_lat_s == CNT_W'(k)) && slot_valid_r[k]);
        end
        // An older write to the same register must land strictly earlier.
        for (int k = 0; k < MAX_LAT; k++) begin
            waw_s = waw_s | ((CNT_W'(k) >= eff_lat_s) && hitd_s[k]);
        end
        struct_s = struct_s & issue_valid & issue_wr;
        waw_s    = waw_s & issue_valid & issue_wr & (issue_rd != ZERO_REG);
        raw1_s   = issue_valid & src1_en & (|(hit1_s & RAW_MASK));
        raw2_s   = issue_valid & src2_en & (|(hit2_s & RAW_MASK));
        fwd1_s   = issue_valid & src1_en & hit1_s[0] & BYPASS_EN;
        fwd2_s   = issue_valid & src2_en & hit2_s[0] & BYPASS_EN;
        stall_s  = raw1_s | raw2_s | struct_s | waw_s;
        accept_s = issue_valid & issue_wr & (issue_rd != ZERO_REG) & ~stall_s & ~flush;
    end

    // Next slot contents: shift toward slot 0, then place the accepted write.
    always_comb begin
        nxt_valid_s = {1'b0, slot_valid_r[MAX_LAT-1:1]};
        for (int k = 0; k < MAX_LAT - 1; k++) begin
            nxt_rd_s[k] = slot_rd_r[k + 1];
        end
        nxt_rd_s[MAX_LAT-1] = ZERO_REG;
        load_s = {MAX_LAT{1'b0}};
        for (int k = 0; k < MAX_LAT; k++) begin
            load_s[k]      = accept_s && (eff_lat_s == CNT_W'(k + 1));
            nxt_valid_s[k] = nxt_valid_s[k] | load_s[k];
            nxt_rd_s[k]    = load_s[k] ? issue_rd : nxt_rd_s[k];
        end
    end

    // Slot state and occupancy count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_valid_r <= {MAX_LAT{1'b0}};
            for (int k = 0; k < MAX_LAT; k++) begin
                slot_rd_r[k] <= ZERO_REG;
            end
            pending_r <= {CNT_W{1'b0}};
        end else begin
            slot_valid_r <= nxt_valid_s;
            // Invalid slots always carry rd 0, so wb_rd reads 0 when idle.
            for (int k = 0; k < MAX_LAT; k++) begin
                slot_rd_r[k] <= nxt_valid_s[k] ? nxt_rd_s[k] : ZERO_REG;
            end
            pending_r <= popcount(nxt_valid_s);
        end
    end

    assign stall       = stall_s;
    assign fwd1        = fwd1_s;
    assign fwd2        = fwd2_s;
    assign wb_valid    = slot_valid_r[0];
    assign wb_rd       = slot_rd_r[0];
    assign pending_cnt = pending_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Reference model: a list of in-flight writes, each {rd, absolute due cycle}.
// Hazards are derived from those due times; accepted issues push their expected
// writeback into a due-ordered queue that an independent monitor drains when
// the DUT presents wb_valid.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

    localparam int RW  = 5;
    localparam int ML  = 8;
    localparam int CW  = 4;
    localparam int BYP = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          issue_valid = 1'b0;
    logic          issue_wr = 1'b0;
    logic [RW-1:0] issue_rd = '0;
    logic [CW-1:0] issue_lat = '0;
    logic          src1_en = 1'b0;
    logic          src2_en = 1'b0;
    logic [RW-1:0] src1 = '0;
    logic [RW-1:0] src2 = '0;
    logic          flush = 1'b0;
    logic          stall;
    logic          fwd1;
    logic          fwd2;
    logic          wb_valid;
    logic [RW-1:0] wb_rd;
    logic [CW-1:0] pending_cnt;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .REG_ADDR_W(RW), .MAX_LAT(ML), .CNT_W(CW), .WB_BYPASS(BYP)
    ) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_wr(issue_wr),
        .issue_rd(issue_rd), .issue_lat(issue_lat),
        .src1_en(src1_en), .src2_en(src2_en), .src1(src1), .src2(src2),
        .flush(flush), .stall(stall), .fwd1(fwd1), .fwd2(fwd2),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .pending_cnt(pending_cnt)
    );

    typedef struct {
        int rd;
        int due;
    } wr_t;

    wr_t inflight[$];
    wr_t exp_q[$];
    wr_t mon_e;
    int  cyc = 0;
    int  n_checks = 0;
    int  n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int clamp(input int lat);
        if (lat == 0) return 1;
        if (lat > ML) return ML;
        return lat;
    endfunction

    // Is there an in-flight write to register r landing in cycles [lo, hi]?
    function automatic bit write_between(input int r, input int lo, input int hi);
        foreach (inflight[i])
            if (inflight[i].rd == r && inflight[i].due >= lo && inflight[i].due <= hi) return 1'b1;
        return 1'b0;
    endfunction

    // Is any write landing exactly in cycle c?
    function automatic bit port_busy(input int c);
        foreach (inflight[i]) if (inflight[i].due == c) return 1'b1;
        return 1'b0;
    endfunction

    // One decode cycle: drive inputs, check stall/forward/occupancy, update model.
    task automatic step(input bit v, input bit wr, input int rd, input int lat,
                        input bit e1, input int s1, input bit e2, input int s2,
                        input bit fl);
        int  l;
        int  far;
        int  raw_lo;
        int  idx;
        bit  raw1, raw2, f1, f2, st, waw, stall_m, acc;
        wr_t e;
        @(negedge clk);
        issue_valid = v;  issue_wr = wr;  issue_rd = RW'(rd);  issue_lat = CW'(lat);
        src1_en = e1;  src1 = RW'(s1);  src2_en = e2;  src2 = RW'(s2);  flush = fl;
        #1;
        if (!rst) inflight.delete();
        for (int i = inflight.size() - 1; i >= 0; i--)
            if (inflight[i].due < cyc) inflight.delete(i);
        l      = clamp(lat);
        far    = cyc + 1000;
        raw_lo = (BYP != 0) ? cyc + 1 : cyc;
        raw1 = v && e1 && s1 != 0 && write_between(s1, raw_lo, far);
        raw2 = v && e2 && s2 != 0 && write_between(s2, raw_lo, far);
        f1   = v && e1 && s1 != 0 && (BYP != 0) && write_between(s1, cyc, cyc);
        f2   = v && e2 && s2 != 0 && (BYP != 0) && write_between(s2, cyc, cyc);
        st   = v && wr && l < ML && port_busy(cyc + l);
        waw  = v && wr && rd != 0 && write_between(rd, cyc + l, far);
        stall_m = raw1 || raw2 || st || waw;
        acc  = v && wr && rd != 0 && !stall_m && !fl && rst;
        chk("stall", int'(stall), int'(stall_m));
        chk("fwd1", int'(fwd1), int'(f1));
        chk("fwd2", int'(fwd2), int'(f2));
        chk("pending_cnt", int'(pending_cnt), inflight.size());
        if (acc) begin
            e.rd  = rd;
            e.due = cyc + l;
            inflight.push_back(e);
            idx = exp_q.size();
            for (int i = 0; i < exp_q.size(); i++)
                if (exp_q[i].due > e.due) begin idx = i; break; end
            exp_q.insert(idx, e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic set_rst(input bit level);
        @(negedge clk);
        issue_valid = 1'b0;  issue_wr = 1'b0;  flush = 1'b0;  src1_en = 1'b0;  src2_en = 1'b0;
        #2;
        rst = level;
        if (!level) begin
            inflight.delete();
            exp_q.delete();
        end
    endtask

    // Writeback monitor: pops the expected write whenever the DUT reports one.
    always @(negedge clk) begin
        if (rst) begin
            if (wb_valid) begin
                if (exp_q.size() == 0) begin
                    chk("wb_unexpected", int'(wb_valid), 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wb_rd", int'(wb_rd), mon_e.rd);
                    chk("wb_time", cyc, mon_e.due);
                end
            end else begin
                chk("wb_rd_idle", int'(wb_rd), 0);
                if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                    mon_e = exp_q.pop_front();
                    chk("wb_missing", int'(wb_valid), 1);
                end
            end
        end
    end

    initial begin
        // Reset: nothing pending, no stall even with a live consumer.
        step(1, 1, 5, 1, 1, 5, 0, 0, 0);
        chk("rst_stall", int'(stall), 0);
        chk("rst_wb_valid", int'(wb_valid), 0);
        chk("rst_pending", int'(pending_cnt), 0);
        set_rst(1'b1);
        step(1, 0, 0, 0, 1, 5, 0, 0, 0);
        chk("post_rst_stall", int'(stall), 0);
        idle(3);

        // Latency 1: consumer in the writeback cycle forwards.
        step(1, 1, 3, 1, 0, 0, 0, 0, 0);
        chk("lat1_issue_stall", int'(stall), 0);
        step(1, 0, 0, 0, 1, 3, 0, 0, 0);
        chk("lat1_stall", int'(stall), 0);
        chk("lat1_fwd1", int'(fwd1), 1);
        chk("lat1_wb_valid", int'(wb_valid), 1);
        chk("lat1_wb_rd", int'(wb_rd), 3);
        idle(3);

        // Latency 4: three stall cycles then forward.
        step(1, 1, 7, 4, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 0, 0, 1, 7, 0);
            chk("lat4_raw_stall", int'(stall), 1);
        end
        step(1, 0, 0, 0, 0, 0, 1, 7, 0);
        chk("lat4_stall", int'(stall), 0);
        chk("lat4_fwd2", int'(fwd2), 1);
        chk("lat4_wb_rd", int'(wb_rd), 7);
        idle(4);

        // Structural: write port collision, then a non-colliding latency.
        step(1, 1, 2, 3, 0, 0, 0, 0, 0);
        step(1, 1, 4, 2, 0, 0, 0, 0, 0);
        chk("struct_stall", int'(stall), 1);
        idle(6);
        step(1, 1, 2, 3, 0, 0, 0, 0, 0);
        step(1, 1, 4, 3, 0, 0, 0, 0, 0);
        chk("struct_ok", int'(stall), 0);
        idle(6);

        // WAW, then latency clamps at both ends.
        step(1, 1, 9, 5, 0, 0, 0, 0, 0);
        step(1, 1, 9, 2, 0, 0, 0, 0, 0);
        chk("waw_stall", int'(stall), 1);
        idle(8);
        step(1, 1, 10, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 10, 0, 0, 0);
        chk("lat0_fwd1", int'(fwd1), 1);
        idle(2);
        step(1, 1, 11, 15, 0, 0, 0, 0, 0);
        idle(8);
        chk("lat15_wb_valid", int'(wb_valid), 1);
        chk("lat15_wb_rd", int'(wb_rd), 11);
        idle(4);

        // Flush: suppressed issues leave the slots alone; stall still reported.
        step(1, 1, 6, 4, 0, 0, 0, 0, 0);
        step(1, 1, 6, 2, 0, 0, 0, 0, 1);
        chk("flush_stall_reported", int'(stall), 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("flush_pending", int'(pending_cnt), 1);
        step(1, 1, 20, 3, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("flush_pending2", int'(pending_cnt), 1);
        idle(8);

        // Reset mid-flight discards three pending writes.
        step(1, 1, 12, 8, 0, 0, 0, 0, 0);
        step(1, 1, 13, 8, 0, 0, 0, 0, 0);
        step(1, 1, 14, 8, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("pre_rst_pending", int'(pending_cnt), 3);
        set_rst(1'b0);
        #1;
        chk("mid_rst_pending", int'(pending_cnt), 0);
        chk("mid_rst_wb_valid", int'(wb_valid), 0);
        idle(2);
        set_rst(1'b1);
        idle(12);

        // Randomized traffic over a small register window to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(9, 0) < 7, ($urandom % 4) != 0,
                 int'($urandom_range(7, 0)), int'($urandom_range(15, 0)),
                 $urandom_range(1, 0) == 1, int'($urandom_range(7, 0)),
                 $urandom_range(1, 0) == 1, int'($urandom_range(7, 0)),
                 $urandom_range(9, 0) == 0);
        end
        idle(12);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
